sdc_sclk_gen: RTL and testbench
===============================

SDC_SCLK_GEN -- requirements
Module: sdc_sclk_gen

Interface
REQ-001 Parameters SHALL be:
- CNT_W, 10: width of the half-period counter and the divider input.
- DIV_INIT, 135: half-period in clock cycles after reset (100 kHz).
- BURST_EDGES, 16: SCLK edges per burst (8 bits).
- GAP_CYC, 540: idle cycles after a burst.
- CPOL, 0: SCLK idle level.
REQ-002 Clock and reset SHALL be i_clk_27_MHz and i_rst, where i_rst is asynchronous and active-high.
REQ-003 Ports SHALL be, in this order:
- i_clk_27_MHz, in, 1: 27 MHz system clock.
- i_rst, in, 1: asynchronous active-high reset.
- i_en, in, 1: free-run enable, used when i_burst=0.
- i_burst, in, 1: mode select; 1=burst, 0=free-run.
- i_start, in, 1: one-cycle pulse that starts a burst.
- i_div, in, CNT_W: requested half-period in cycles.
- i_div_load, in, 1: one-cycle pulse that latches i_div.
- o_sclk, out, 1: generated SD/SPI clock.
- o_rise, out, 1: one-cycle strobe, high in the first cycle o_sclk reads 1.
- o_fall, out, 1: one-cycle strobe, high in the first cycle o_sclk reads 0.
- o_busy, out, 1: high while in RUN or GAP.
- o_done, out, 1: one-cycle pulse at burst completion.

Function
REQ-004 The FSM SHALL have states IDLE, RUN and GAP; all outputs SHALL be registered.
REQ-005 IDLE -> RUN SHALL occur on i_start=1 with i_burst=1, or on i_en=1 with i_burst=0.
REQ-006 In RUN, the counter SHALL count 0..div_act-1; at div_act-1 it SHALL wrap to 0 and o_sclk SHALL toggle.
- SCLK period is therefore 2*div_act cycles.
- The first toggle SHALL occur div_act cycles after entering RUN.
REQ-007 div_act SHALL be max(div_pend,1), so that i_div=0 behaves as 1.
REQ-008 i_div_load SHALL latch i_div into div_pend at any time.
- div_act SHALL take the value of div_pend only when the counter wraps and o_sclk returns to the CPOL level, or while in IDLE.
- The output SHALL never produce a partial (glitch) half-period.
REQ-009 o_rise and o_fall SHALL each be high exactly one cycle per edge, coincident with the o_sclk change, and never both high in the same cycle.
REQ-010 In burst mode, the edge counter SHALL count toggles.
- After BURST_EDGES toggles (o_sclk back at CPOL), the FSM SHALL enter GAP with o_sclk held at CPOL.
REQ-011 GAP SHALL last GAP_CYC cycles.
- It SHALL then go to IDLE, asserting o_done for one cycle on the GAP -> IDLE transition.
- o_busy SHALL go low in the same cycle.
REQ-012 i_start SHALL be ignored while o_busy=1.
REQ-013 In free-run mode, deasserting i_en SHALL stop the clock at the next toggle that returns o_sclk to CPOL.
- The FSM SHALL then go directly to IDLE, with no GAP and no o_done.
REQ-014 A change of i_burst while o_busy=1 SHALL be ignored; the mode SHALL be sampled on the IDLE -> RUN transition.
REQ-015 In IDLE, o_sclk SHALL be CPOL, the counters SHALL be 0, and no strobes SHALL be asserted.

Reset
REQ-016 While i_rst=1, the following SHALL hold immediately (asynchronous):
- o_sclk=CPOL; o_rise, o_fall, o_busy and o_done all 0.
- State IDLE; all counters 0.
- div_pend=div_act=DIV_INIT.
REQ-017 Reset asserted mid-burst SHALL abort the burst with no o_done.
- After reset release, the block SHALL wait in IDLE for a new i_start.

Structure
REQ-018 The FSM state encoding and DIV_INIT_400K=34 / DIV_100K=135 (values at 27 MHz) SHALL reside in the shared package sdc_pkg.
REQ-019 The block SHALL be a single module.
- The half-period counter with its glitch-free reload MAY be a sub-module named sdc_halfper_cnt.

Verification
REQ-020 Reset release, i_burst=0, i_en=1, no i_div_load -> o_sclk period 270 cycles, first rise 135 cycles after entry to RUN, o_rise once per 270 cycles.
REQ-021 i_div=2 loaded, i_burst=1, i_start pulse -> 8 o_rise, 8 o_fall, busy 32 cycles in RUN, then 540 cycles in GAP, then a single o_done, o_sclk=0 throughout GAP.
REQ-022 Free-run at div 135, i_div_load with i_div=34 while o_sclk=1 -> the current high half stays 135 cycles, and subsequent half-periods are 34 cycles.
REQ-023 i_div=0 loaded, free-run -> o_sclk toggles every cycle, with o_rise/o_fall alternating each cycle.
REQ-024 i_rst pulsed after the 5th edge of a burst -> o_sclk=0 and o_busy=0 immediately, no o_done, and the next i_start produces a full 16-edge burst.
REQ-025 i_start pulsed while busy, plus i_burst toggled mid-burst -> ignored, and the burst completes with exactly 16 edges.

Source files
------------

// File: rtl/sdc_pkg.sv
// Shared SD clock generator definitions: FSM encoding and
// 27 MHz half-period presets.
`timescale 1ns/1ps
package sdc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } sclk_state_e;

  localparam int DIV_INIT_400K = 34;
  localparam int DIV_100K      = 135;

endpackage

// File: rtl/sdc_halfper_cnt.sv
// Half-period counter with glitch-free divider reload.
// Reload only in idle or on the wrap that returns SCLK to idle level.
`timescale 1ns/1ps
module sdc_halfper_cnt
  import sdc_pkg::*;
#(
  parameter int CNT_W    = 10,
  parameter int DIV_INIT = DIV_100K
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             idle_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             div_load_i,
  input  logic             at_cpol_i,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] DIV_RST =
    (DIV_INIT == 0) ? CNT_W'(1) : CNT_W'(DIV_INIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] pend_clamp;

  assign wrap_o = run_i && (cnt_q == act_q - 1'b1);

  // A zero divider behaves as one.
  assign pend_clamp = (pend_q == '0) ? CNT_W'(1) : pend_q;

  always_comb begin
    cnt_d  = '0;
    pend_d = pend_q;
    act_d  = act_q;
    if (run_i && !wrap_o) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (div_load_i) begin
      pend_d = div_i;
    end
    if (idle_i || (wrap_o && !at_cpol_i)) begin
      act_d = pend_clamp;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      pend_q <= DIV_RST;
      act_q  <= DIV_RST;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      act_q  <= act_d;
    end
  end

endmodule

// File: rtl/sdc_sclk_gen.sv
// SD/SPI serial clock generator: free-run or fixed-length bursts
// followed by an idle gap, with registered edge strobes.
`timescale 1ns/1ps
module sdc_sclk_gen
  import sdc_pkg::*;
#(
  parameter int   CNT_W       = 10,
  parameter int   DIV_INIT    = DIV_100K,
  parameter int   BURST_EDGES = 16,
  parameter int   GAP_CYC     = 540,
  parameter logic CPOL        = 1'b0
) (
  input  logic             i_clk_27_MHz,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_burst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_div,
  input  logic             i_div_load,
  output logic             o_sclk,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_busy,
  output logic             o_done
);

  localparam int EDGE_W = $clog2(BURST_EDGES + 1);
  localparam int GAP_W  = $clog2(GAP_CYC + 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(BURST_EDGES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);

  sclk_state_e state_q, state_d;
  logic              mode_q, mode_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              sclk_q, sclk_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic run, idle, at_cpol, wrap;

  assign run     = (state_q == RUN);
  assign idle    = (state_q == IDLE);
  assign at_cpol = (sclk_q == CPOL);

  sdc_halfper_cnt #(
    .CNT_W    (CNT_W),
    .DIV_INIT (DIV_INIT)
  ) u_halfper (
    .clk_i      (i_clk_27_MHz),
    .rst_i      (i_rst),
    .run_i      (run),
    .idle_i     (idle),
    .div_i      (i_div),
    .div_load_i (i_div_load),
    .at_cpol_i  (at_cpol),
    .wrap_o     (wrap)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    edge_d  = edge_q;
    gap_d   = gap_q;
    sclk_d  = sclk_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        sclk_d = CPOL;
        edge_d = '0;
        gap_d  = '0;
        if (i_burst && i_start) begin
          state_d = RUN;
          mode_d  = 1'b1;
        end else if (!i_burst && i_en) begin
          state_d = RUN;
          mode_d  = 1'b0;
        end
      end
      RUN: begin
        if (wrap) begin
          sclk_d = ~sclk_q;
          rise_d = ~sclk_q;
          fall_d = sclk_q;
          if (mode_q) begin
            if (edge_q == EDGE_LAST) begin
              edge_d  = '0;
              state_d = GAP;
            end else begin
              edge_d = edge_q + 1'b1;
            end
          end else if (!at_cpol && !i_en) begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        sclk_d = CPOL;
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk_27_MHz or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      edge_q  <= '0;
      gap_q   <= '0;
      sclk_q  <= CPOL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      edge_q  <= edge_d;
      gap_q   <= gap_d;
      sclk_q  <= sclk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_sclk = sclk_q;
  assign o_rise = rise_q;
  assign o_fall = fall_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_sdc_sclk_gen.sv
// Directed bench for sdc_sclk_gen: free-run, divider reload,
// bursts, mid-burst reset and ignored controls while busy.
`timescale 1ns/1ps
module tb_sdc_sclk_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       burst = 1'b0;
  logic       start = 1'b0;
  logic [9:0] div = '0;
  logic       div_load = 1'b0;
  logic       o_sclk, o_rise, o_fall, o_busy, o_done;

  int vec = 0;
  int err = 0;

  sdc_sclk_gen dut (
    .i_clk_27_MHz (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_burst      (burst),
    .i_start      (start),
    .i_div        (div),
    .i_div_load   (div_load),
    .o_sclk       (o_sclk),
    .o_rise       (o_rise),
    .o_fall       (o_fall),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_div(input logic [9:0] v);
    div = v;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    vec++;
    if ({o_sclk, o_rise, o_fall, o_busy, o_done} !== 5'b0) begin
      err++;
      $display("FAIL rst_outs: got %b want 00000",
               {o_sclk, o_rise, o_fall, o_busy, o_done});
    end
    rst = 1'b0;
    repeat (2) tick();
    vec++;
    if (o_busy !== 1'b0) begin
      err++;
      $display("FAIL rst_idle_busy: got %b want 0", o_busy);
    end
  endtask

  task automatic test_freerun;
    int n;
    burst = 1'b0;
    en = 1'b1;
    tick();
    vec++;
    if (o_busy !== 1'b1 || o_sclk !== 1'b0) begin
      err++;
      $display("FAIL fr_enter: got busy=%b sclk=%b want 1/0",
               o_busy, o_sclk);
    end
    n = 0;
    do begin tick(); n++; end while (!o_rise && n < 400);
    vec++;
    if (n != 135 || o_sclk !== 1'b1) begin
      err++;
      $display("FAIL fr_first_rise: got %0d want 135", n);
    end
    n = 0;
    do begin tick(); n++; end while (!o_fall && n < 400);
    vec++;
    if (n != 135) begin
      err++;
      $display("FAIL fr_high_half: got %0d want 135", n);
    end
    n = 0;
    do begin tick(); n++; end while (!o_rise && n < 400);
    vec++;
    if (n != 135) begin
      err++;
      $display("FAIL fr_low_half: got %0d want 135", n);
    end
    en = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!o_fall && n < 400);
    vec++;
    if (n != 135 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      err++;
      $display("FAIL fr_stop: got n=%0d busy=%b done=%b want 135/0/0",
               n, o_busy, o_done);
    end
    n = 0;
    repeat (10) begin
      tick();
      if (o_busy || o_done || o_sclk || o_rise) n++;
    end
    vec++;
    if (n != 0) begin
      err++;
      $display("FAIL fr_idle_after: got %0d active cycles want 0", n);
    end
  endtask

  task automatic test_div_change;
    int n;
    en = 1'b1;
    tick();
    n = 0;
    do begin tick(); n++; end while (!o_rise && n < 400);
    vec++;
    if (n != 135) begin
      err++;
      $display("FAIL dc_rise: got %0d want 135", n);
    end
    div = 10'd34;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
    n = 1;
    while (!o_fall && n < 400) begin tick(); n++; end
    vec++;
    if (n != 135) begin
      err++;
      $display("FAIL dc_high_kept: got %0d want 135", n);
    end
    n = 0;
    do begin tick(); n++; end while (!o_rise && n < 400);
    vec++;
    if (n != 34) begin
      err++;
      $display("FAIL dc_low_new: got %0d want 34", n);
    end
    n = 0;
    do begin tick(); n++; end while (!o_fall && n < 400);
    vec++;
    if (n != 34) begin
      err++;
      $display("FAIL dc_high_new: got %0d want 34", n);
    end
    en = 1'b0;
    n = 0;
    do begin tick(); n++; end while (o_busy && n < 400);
    vec++;
    if (n != 68 || o_fall !== 1'b1) begin
      err++;
      $display("FAIL dc_stop: got n=%0d fall=%b want 68/1", n, o_fall);
    end
  endtask

  task automatic test_div0;
    logic [2:0] exp;
    load_div(10'd0);
    en = 1'b1;
    tick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp = (k % 2 == 1) ? 3'b110 : 3'b001;
      vec++;
      if ({o_sclk, o_rise, o_fall} !== exp) begin
        err++;
        $display("FAIL d0_cycle%0d: got %b want %b",
                 k, {o_sclk, o_rise, o_fall}, exp);
      end
    end
    en = 1'b0;
    tick();
    tick();
    vec++;
    if ({o_sclk, o_fall, o_busy} !== 3'b010) begin
      err++;
      $display("FAIL d0_stop: got %b want 010", {o_sclk, o_fall, o_busy});
    end
  endtask

  task automatic test_burst;
    int n, rises, falls, last_e, done_at, gap_bad, busy_bad;
    load_div(10'd2);
    burst = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    vec++;
    if (o_busy !== 1'b1) begin
      err++;
      $display("FAIL b_busy: got %b want 1", o_busy);
    end
    n = 0; rises = 0; falls = 0; last_e = 0;
    done_at = 0; gap_bad = 0; busy_bad = 0;
    while (done_at == 0 && n < 2000) begin
      tick();
      n++;
      if (o_rise) begin rises++; last_e = n; end
      if (o_fall) begin falls++; last_e = n; end
      if (o_done) done_at = n;
      if (rises == 8 && falls == 8 && o_sclk) gap_bad++;
      if (!o_done && !o_busy) busy_bad++;
    end
    vec++;
    if (rises != 8 || falls != 8) begin
      err++;
      $display("FAIL b_edges: got %0d/%0d want 8/8", rises, falls);
    end
    vec++;
    if (last_e != 32) begin
      err++;
      $display("FAIL b_run_len: got %0d want 32", last_e);
    end
    vec++;
    if (done_at != 572 || o_busy !== 1'b0) begin
      err++;
      $display("FAIL b_done: got at=%0d busy=%b want 572/0",
               done_at, o_busy);
    end
    vec++;
    if (gap_bad != 0 || busy_bad != 0) begin
      err++;
      $display("FAIL b_gap: got sclk_hi=%0d busy_lo=%0d want 0/0",
               gap_bad, busy_bad);
    end
    n = 0;
    repeat (5) begin tick(); if (o_done || o_busy) n++; end
    vec++;
    if (n != 0) begin
      err++;
      $display("FAIL b_single_done: got %0d want 0", n);
    end
  endtask

  task automatic test_reset_mid;
    int n, edges, done_at, last_e, bad;
    burst = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; edges = 0;
    while (edges < 5 && n < 100) begin
      tick();
      n++;
      if (o_rise || o_fall) edges++;
    end
    vec++;
    if (edges != 5 || o_sclk !== 1'b1) begin
      err++;
      $display("FAIL rm_pre: got edges=%0d sclk=%b want 5/1", edges, o_sclk);
    end
    #2 rst = 1'b1;
    #1;
    vec++;
    if ({o_sclk, o_busy, o_done, o_rise, o_fall} !== 5'b0) begin
      err++;
      $display("FAIL rm_async: got %b want 00000",
               {o_sclk, o_busy, o_done, o_rise, o_fall});
    end
    tick();
    rst = 1'b0;
    bad = 0;
    repeat (20) begin tick(); if (o_busy || o_done || o_sclk) bad++; end
    vec++;
    if (bad != 0) begin
      err++;
      $display("FAIL rm_wait: got %0d active cycles want 0", bad);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; edges = 0; done_at = 0; last_e = 0;
    while (done_at == 0 && n < 4000) begin
      tick();
      n++;
      if (o_rise || o_fall) begin edges++; last_e = n; end
      if (o_done) done_at = n;
    end
    vec++;
    if (edges != 16 || last_e != 2160 || done_at != 2700) begin
      err++;
      $display("FAIL rm_reburst: got e=%0d last=%0d done=%0d want 16/2160/2700",
               edges, last_e, done_at);
    end
  endtask

  task automatic test_back_to_back;
    int n, edges, done_at, last_e, bad;
    load_div(10'd2);
    burst = 1'b1;
    en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; edges = 0; done_at = 0; last_e = 0;
    while (done_at == 0 && n < 2000) begin
      tick();
      n++;
      if (o_rise || o_fall) begin edges++; last_e = n; end
      if (o_done) done_at = n;
      start = (n == 5 || n == 100);
      if (n == 9) burst = 1'b0;
      if (n == 50) burst = 1'b1;
    end
    start = 1'b0;
    vec++;
    if (edges != 16 || last_e != 32) begin
      err++;
      $display("FAIL bb_edges: got e=%0d last=%0d want 16/32", edges, last_e);
    end
    vec++;
    if (done_at != 572) begin
      err++;
      $display("FAIL bb_done: got %0d want 572", done_at);
    end
    bad = 0;
    repeat (5) begin tick(); if (o_busy || o_done) bad++; end
    vec++;
    if (bad != 0) begin
      err++;
      $display("FAIL bb_idle: got %0d active cycles want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_freerun();
    test_div_change();
    test_div0();
    test_burst();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
